bcd_conv_sched: RTL and testbench
=================================

Name: bcd_conv_sched

Overview:
- Shares one iterative (one bit per cycle) binary-to-BCD double-dabble engine among NCH sensor/display requesters in the aquarium monitor.
- Arbitrates requests round-robin, sequences the shift/add-3 iterations, and returns the BCD result tagged with the requester's channel over a valid/ready handshake.
- Sits between the sensor scaling logic and the 7-segment display formatter.

Parameters:
- N, 8, binary input width per channel.
- NCH, 4, number of requesters (>=2).
- CW, $clog2(NCH), channel index width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NCH  per-channel conversion request. The requester holds req and its bin slice stable until it sees its gnt bit.
- bin  input  NCH*N  packed binary operands; channel i is bin[i*N +: N].
- gnt  output  NCH  one-hot, one-cycle pulse acknowledging capture of a channel's operand.
- busy  output  1  high from capture until the result handshake completes.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_bcd  output  N+4  packed BCD result, least significant digit in bits [3:0].
- out_ch  output  CW  channel index that produced out_bcd.

Behaviour:
- Reset (async, rst_n low):
  - gnt=0, busy=0, out_valid=0, out_bcd=0, out_ch=0.
  - FSM goes to IDLE; rr_ptr=0; shift register=0; bit counter=0.
  - Reset asserted mid-conversion discards the conversion, with no result and no gnt.
- Internal datapath:
  - Shift register sr, width 2N+4. Binary operand in sr[N-1:0]; BCD digits form in sr[2N+3:N].
  - Down-counter cnt, $clog2(N+1) bits.
- IDLE:
  - If req is nonzero, select the first asserted channel scanning upward from rr_ptr, wrapping NCH-1 -> 0.
  - At the edge: sr = {0, bin[sel]}, cnt = N, ch = sel. Next cycle gnt[sel]=1 (exactly one cycle), busy=1, state -> SHIFT.
  - If req is zero, remain in IDLE. gnt is never asserted outside this transition.
- SHIFT, one iteration per cycle:
  - For every nibble at sr offset j = N, N+4, ... while j <= 2N: if nibble >= 5, add 3 (4-bit wrap, no carry between nibbles).
  - Then shift the whole sr left by 1 and decrement cnt.
  - On the iteration where cnt goes 1 -> 0, state -> DONE.
  - Exactly N SHIFT cycles. req changes during SHIFT are ignored.
- DONE:
  - out_valid=1, out_bcd = sr[2N+3:N], out_ch = ch. All three are registered and stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: out_valid=0, busy=0, rr_ptr = (ch+1) mod NCH, state -> IDLE.
  - out_bcd and out_ch retain their last value after the handshake.
- Latency: req sampled at edge k -> gnt high in cycle k+1 -> out_valid high in cycle k+N+1. With out_ready tied high, a back-to-back request is captured in the first IDLE cycle after the handshake. Throughput is one result per N+2 cycles.
- Arbitration:
  - Round-robin; the channel served last has lowest priority next time.
  - Under continuous requests from all channels, service order is 0,1,...,NCH-1,0,...
  - A channel never waits more than NCH-1 other conversions.
- Arithmetic: result equals the decimal representation of the unsigned operand. For N=8, max 255 -> 0x255; upper digits are zero for smaller values.
- Simultaneous events:
  - out_ready high on the same cycle out_valid first rises completes the handshake in that cycle.
  - A req held through gnt without being dropped is treated as a new request on the next IDLE visit.

Test Plan:
- Single request, N=8: req=0001, bin[7:0]=255, out_ready=1 -> gnt=0001 one cycle; out_valid in cycle k+9 with out_bcd=0x255, out_ch=0; busy low after the handshake.
- Boundary values: operands 0, 9, 10, 99, 100, 199 on channel 2 -> out_bcd 0x000, 0x009, 0x010, 0x099, 0x100, 0x199; out_ch=2 each time.
- Exhaustive sweep of 0..255 over random channels against a golden decimal model -> all results match; no gnt while busy=1.
- Round-robin: req=1111 held continuously, distinct operands -> out_ch sequence 0,1,2,3,0,1 with matching BCD values. After channel 2 is served, req=0101 -> channel 0 is granted next.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_bcd/out_ch/out_valid stable, busy=1, no gnt despite pending req. out_ready high -> handshake, next grant one cycle later.
- Reset mid-SHIFT (after 3 iterations): rst_n low asynchronously -> all outputs 0 immediately, no out_valid after release. rr_ptr=0, so req=1010 then grants channel 1 first.

Source files
------------

// File: rtl/bcd_conv_sched.sv
// ---------------------------------------------------------------------------
// bcd_conv_sched
//
// Purpose:
//   Shares a single iterative double-dabble binary-to-BCD engine (one bit per
//   clock) among NCH requesters. A round-robin arbiter picks a requester,
//   captures its operand and acknowledges it with a one-cycle gnt pulse. The
//   engine then runs N shift/add-3 iterations. The BCD result, tagged with the
//   channel index, is returned over a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-channel request; held with its bin slice until gnt is seen
//   bin        packed operands, channel i at bin[i*N +: N]
//   gnt        one-hot, one-cycle capture acknowledge
//   busy       high from capture until the result handshake completes
//   out_valid  result available (registered)
//   out_ready  consumer accepts the result
//   out_bcd    packed BCD result, least significant digit in [3:0]
//   out_ch     channel index that produced out_bcd
// ---------------------------------------------------------------------------
module bcd_conv_sched #(
    parameter int N   = 8,
    parameter int NCH = 4,
    // Derived from NCH; not meant to be overridden.
    parameter int CW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*N-1:0]     bin,
    output logic [NCH-1:0]       gnt,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N+3:0]         out_bcd,
    output logic [CW-1:0]        out_ch
);

    localparam int SW   = 2 * N + 4;         // shift register width
    localparam int ND   = N / 4 + 1;         // BCD nibbles at offsets N, N+4, ... <= 2N
    localparam int TOP  = N + 4 * ND;        // first bit above the highest nibble
    localparam int CNTW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       sr_q, sr_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [CW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NCH-1:0]      gnt_q, gnt_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [N+3:0]        out_bcd_q, out_bcd_d;
    logic [CW-1:0]       out_ch_q, out_ch_d;

    // -----------------------------------------------------------------------
    // Operand unpacking
    // -----------------------------------------------------------------------
    logic [N-1:0] bin_ch [NCH];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
        assign bin_ch[gi] = bin[gi*N +: N];
    end

    // -----------------------------------------------------------------------
    // Round-robin candidate list: slot gi holds channel (rr_ptr + gi) mod NCH,
    // so slot 0 is the highest-priority channel this round.
    // -----------------------------------------------------------------------
    logic [CW-1:0] cand_idx [NCH];
    logic [NCH-1:0] cand_req;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
        logic [CW:0] sum;
        assign sum          = {1'b0, rr_ptr_q} + (CW+1)'(gi);
        assign cand_idx[gi] = (sum >= (CW+1)'(NCH)) ? CW'(sum - (CW+1)'(NCH)) : CW'(sum);
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    logic          sel_found;
    logic [CW-1:0] sel_idx;

    // Scan from the lowest-priority slot upward so the last hit (the
    // highest-priority asserted slot) wins without needing a loop break.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Double-dabble correction: each BCD nibble >= 5 gets +3 before the shift
    // so that the shift carries correctly into the next decimal digit. The
    // 4-bit add wraps by construction; nibbles never carry into each other.
    // -----------------------------------------------------------------------
    logic [SW-1:0] sr_adj;

    assign sr_adj[N-1:0] = sr_q[N-1:0];

    for (genvar gi = 0; gi < ND; gi++) begin : g_add3
        localparam int OFF = N + 4 * gi;
        assign sr_adj[OFF+3:OFF] = (sr_q[OFF+3:OFF] >= 4'd5) ?
                                   (sr_q[OFF+3:OFF] + 4'd3) : sr_q[OFF+3:OFF];
    end

    if (TOP < SW) begin : g_pass_top
        assign sr_adj[SW-1:TOP] = sr_q[SW-1:TOP];
    end

    // Next round-robin pointer: the channel after the one just served.
    logic [CW:0]   ch_inc;
    logic [CW-1:0] ch_next;

    assign ch_inc  = {1'b0, ch_q} + (CW+1)'(1);
    assign ch_next = (ch_inc >= (CW+1)'(NCH)) ? '0 : CW'(ch_inc);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = '0;           // gnt is a single-cycle pulse
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_bcd_d   = out_bcd_q;
        out_ch_d    = out_ch_q;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    sr_d    = {{(SW-N){1'b0}}, bin_ch[sel_idx]};
                    cnt_d   = CNTW'(N);
                    ch_d    = sel_idx;
                    gnt_d   = NCH'(1) << sel_idx;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                sr_d  = sr_adj << 1;
                cnt_d = cnt_q - CNTW'(1);
                // Final iteration: publish the freshly shifted digits directly
                // so out_valid rises on the same edge the engine finishes.
                if (cnt_q == CNTW'(1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_bcd_d   = sr_d[SW-1:N];
                    out_ch_d    = ch_q;
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    rr_ptr_d    = ch_next;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            ch_q        <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_bcd_q   <= out_bcd_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// ---------------------------------------------------------------------------
// tb_bcd_conv_sched
//
// Directed-plus-random bench for bcd_conv_sched (N=8, NCH=4). Expected
// results come from a decimal-digit model (integer / and %) and a
// round-robin pointer model kept in the bench. Inputs are driven and outputs
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_conv_sched;

    localparam int N   = 8;
    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int BW  = N + 4;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic [NCH-1:0]    req       = '0;
    logic [NCH*N-1:0]  bin       = '0;
    logic [NCH-1:0]    gnt;
    logic              busy;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [BW-1:0]     out_bcd;
    logic [CW-1:0]     out_ch;

    bcd_conv_sched #(.N(N), .NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bin       (bin),
        .gnt       (gnt),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_mis    = 0;
    int ops [NCH];
    int rr_model = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal representation of v, one digit per nibble.
    function automatic logic [BW-1:0] dec_of(input int v);
        logic [BW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < BW / 4; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Round-robin model: first requesting channel at or after rr_model.
    function automatic int pick(input logic [NCH-1:0] rq);
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = (rr_model + i) % NCH;
            if (rq[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_ops();
        for (int i = 0; i < NCH; i++) bin[i*N +: N] = N'(ops[i]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},   gnt,       0);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_bcd"},   out_bcd,   0);
        chk({tag, "_ch"},    out_ch,    0);
    endtask

    // One full conversion: request, grant, N iterations, result, handshake.
    // Called on a falling edge; returns on the falling edge after handshake.
    task automatic txn(input logic [NCH-1:0] rq, input bit keep, input int rdy_delay);
        int ch;
        logic [BW-1:0] eb;
        ch = pick(rq);
        eb = dec_of(ops[ch]);
        set_ops();
        req       = rq;
        out_ready = (rdy_delay == 0);
        @(negedge clk);
        chk("gnt", gnt, 32'(1 << ch));
        chk("busy_cap", busy, 1);
        if (!keep) req = '0;
        for (int c = 1; c < N; c++) begin
            @(negedge clk);
            chk("shift_gnt", gnt, 0);
            chk("shift_valid", out_valid, 0);
        end
        @(negedge clk);
        chk("valid", out_valid, 1);
        chk("bcd", out_bcd, eb);
        chk("ch", out_ch, ch);
        $display("txn req=%b ch=%0d op=%0d bcd=0x%0h ready_delay=%0d", rq, out_ch, ops[ch], out_bcd, rdy_delay);
        if (rdy_delay > 0) begin
            for (int c = 0; c < rdy_delay; c++) begin
                @(negedge clk);
                chk("bp_valid", out_valid, 1);
                chk("bp_bcd", out_bcd, eb);
                chk("bp_ch", out_ch, ch);
                chk("bp_busy", busy, 1);
                chk("bp_gnt", gnt, 0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("hs_valid", out_valid, 0);
        chk("hs_busy", busy, 0);
        chk("hs_gnt", gnt, 0);
        chk("hold_bcd", out_bcd, eb);
        chk("hold_ch", out_ch, ch);
        rr_model = (ch + 1) % NCH;
    endtask

    initial begin
        int bvals [6];
        bvals = '{0, 9, 10, 99, 100, 199};
        for (int i = 0; i < NCH; i++) ops[i] = $urandom_range(0, 255);

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single request, maximum operand
        ops[0] = 255;
        txn(4'b0001, 1'b0, 0);

        // Decimal boundaries on channel 2
        for (int i = 0; i < 6; i++) begin
            ops[2] = bvals[i];
            txn(4'b0100, 1'b0, 0);
        end

        // Full operand sweep over random channels
        for (int v = 0; v < 256; v++) begin
            int c;
            c = $urandom_range(0, NCH - 1);
            for (int i = 0; i < NCH; i++) ops[i] = $urandom_range(0, 255);
            ops[c] = v;
            txn(4'(1 << c), 1'b0, 0);
        end

        // Asynchronous reset after three SHIFT iterations
        ops[0] = $urandom_range(0, 255);
        set_ops();
        out_ready = 1'b1;
        req = 4'b0001;
        @(negedge clk);
        chk("mr_gnt", gnt, 1);
        req = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("mr");
        @(negedge clk);
        rst_n = 1'b1;
        rr_model = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("mr_no_valid", out_valid, 0);
            chk("mr_no_busy", busy, 0);
        end
        for (int i = 0; i < NCH; i++) ops[i] = $urandom_range(0, 255);
        txn(4'b1010, 1'b0, 0);

        // Round-robin under continuous requests, with backpressure on one result
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_model = 0;
        @(negedge clk);
        for (int i = 0; i < NCH; i++) ops[i] = 17 + 60 * i + $urandom_range(0, 40);
        for (int t = 0; t < 7; t++) begin
            txn(4'b1111, 1'b1, (t == 2) ? 5 : 0);
        end
        // Channel 2 served last; with only 0 and 2 requesting, 0 goes next
        txn(4'b0101, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
